// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiply sequencer.
package matmul_pkg;

  localparam int DEFAULT_MATRIX_DIM = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/matmul_index_gen.sv
// Nested i/j/k loop counters (k innermost) with look-ahead values and a last-element flag.
module matmul_index_gen
  import matmul_pkg::*;
#(
  parameter int MATRIX_DIM = DEFAULT_MATRIX_DIM,
  parameter int IDX_W      = $clog2(MATRIX_DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [IDX_W-1:0] o_i,
  output logic [IDX_W-1:0] o_j,
  output logic [IDX_W-1:0] o_k,
  output logic [IDX_W-1:0] o_nxt_i,
  output logic [IDX_W-1:0] o_nxt_j,
  output logic [IDX_W-1:0] o_nxt_k,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MATRIX_DIM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_j;
  logic [IDX_W-1:0] r_k;
  logic             w_i_wrap;
  logic             w_j_wrap;
  logic             w_k_wrap;

  assign w_i_wrap = (r_i == IDX_LAST);
  assign w_j_wrap = (r_j == IDX_LAST);
  assign w_k_wrap = (r_k == IDX_LAST);

  // Carry chain: k wraps into j, j wraps into i
  always_comb begin
    o_nxt_i = r_i;
    o_nxt_j = r_j;
    o_nxt_k = r_k;
    if (w_k_wrap) begin
      o_nxt_k = '0;
      if (w_j_wrap) begin
        o_nxt_j = '0;
        if (w_i_wrap) begin
          o_nxt_i = '0;
        end else begin
          o_nxt_i = r_i + IDX_ONE;
        end
      end else begin
        o_nxt_j = r_j + IDX_ONE;
      end
    end else begin
      o_nxt_k = r_k + IDX_ONE;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (i_clear) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (i_advance) begin
      r_i <= o_nxt_i;
      r_j <= o_nxt_j;
      r_k <= o_nxt_k;
    end else begin
      r_i <= r_i;
      r_j <= r_j;
      r_k <= r_k;
    end
  end

  assign o_i    = r_i;
  assign o_j    = r_j;
  assign o_k    = r_k;
  assign o_last = w_i_wrap && w_j_wrap && w_k_wrap;

endmodule

// File: rtl/matmul_sequencer.sv
// Matrix-multiply sequencer: issues A/B reads for every (i,j,k) and schedules
// MAC and result-write strobes to line up with memory and MAC latency.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int MATRIX_DIM       = DEFAULT_MATRIX_DIM,
  parameter int MATRIX_MEM_DEPTH = MATRIX_DIM * MATRIX_DIM
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                rd_en,
  output logic [$clog2(MATRIX_MEM_DEPTH)-1:0] rd_address_a,
  output logic [$clog2(MATRIX_MEM_DEPTH)-1:0] rd_address_b,
  output logic                                mac_en,
  output logic                                mac_first,
  output logic                                res_wr_en,
  output logic [$clog2(MATRIX_MEM_DEPTH)-1:0] res_wr_address
);

  localparam int ADDR_W = $clog2(MATRIX_MEM_DEPTH);
  localparam int IDX_W  = $clog2(MATRIX_DIM);
  localparam logic [IDX_W-1:0]  K_LAST = IDX_W'(MATRIX_DIM - 1);
  localparam logic [ADDR_W-1:0] DIM_A  = ADDR_W'(MATRIX_DIM);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_start_accept;
  logic              w_issue_nxt;
  logic              w_idx_clear;
  logic              w_idx_advance;
  logic [IDX_W-1:0]  w_i;
  logic [IDX_W-1:0]  w_j;
  logic [IDX_W-1:0]  w_k;
  logic [IDX_W-1:0]  w_nxt_i;
  logic [IDX_W-1:0]  w_nxt_j;
  logic [IDX_W-1:0]  w_nxt_k;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr_a_nxt;
  logic [ADDR_W-1:0] w_addr_b_nxt;
  logic [ADDR_W-1:0] w_waddr_cur;

  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_address_a;
  logic [ADDR_W-1:0] r_rd_address_b;
  logic              r_mac_en;
  logic              r_mac_first;
  logic              r_wr_s1;
  logic [ADDR_W-1:0] r_waddr_s1;
  logic              r_last_s1;
  logic              r_last_s2;
  logic              r_res_wr_en;
  logic [ADDR_W-1:0] r_res_wr_address;

  // Counters follow the element currently on the read outputs; held at zero outside ISSUE.
  assign w_idx_advance = (r_state == ST_ISSUE);
  assign w_idx_clear   = (r_state != ST_ISSUE);

  matmul_index_gen #(
    .MATRIX_DIM (MATRIX_DIM),
    .IDX_W      (IDX_W)
  ) u_index_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_idx_clear),
    .i_advance (w_idx_advance),
    .o_i       (w_i),
    .o_j       (w_j),
    .o_k       (w_k),
    .o_nxt_i   (w_nxt_i),
    .o_nxt_j   (w_nxt_j),
    .o_nxt_k   (w_nxt_k),
    .o_last    (w_last)
  );

  assign w_addr_a_nxt = ADDR_W'(w_nxt_i) * DIM_A + ADDR_W'(w_nxt_k);
  assign w_addr_b_nxt = ADDR_W'(w_nxt_k) * DIM_A + ADDR_W'(w_nxt_j);
  assign w_waddr_cur  = ADDR_W'(w_i) * DIM_A + ADDR_W'(w_j);

  // Next-state and read-issue decision
  always_comb begin
    w_state_nxt    = r_state;
    w_start_accept = 1'b0;
    w_issue_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt    = ST_ISSUE;
          w_start_accept = 1'b1;
          w_issue_nxt    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (w_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_ISSUE;
          w_issue_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_last_s2) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, read issue and the read->MAC->write delay pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_rd_en          <= 1'b0;
      r_rd_address_a   <= '0;
      r_rd_address_b   <= '0;
      r_mac_en         <= 1'b0;
      r_mac_first      <= 1'b0;
      r_wr_s1          <= 1'b0;
      r_waddr_s1       <= '0;
      r_last_s1        <= 1'b0;
      r_last_s2        <= 1'b0;
      r_res_wr_en      <= 1'b0;
      r_res_wr_address <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_rd_en <= w_issue_nxt;
      // The first element is (0,0,0), which the counters already hold in IDLE.
      if (w_start_accept) begin
        r_rd_address_a <= '0;
        r_rd_address_b <= '0;
      end else if (w_issue_nxt) begin
        r_rd_address_a <= w_addr_a_nxt;
        r_rd_address_b <= w_addr_b_nxt;
      end else begin
        r_rd_address_a <= '0;
        r_rd_address_b <= '0;
      end
      r_mac_en         <= r_rd_en;
      r_mac_first      <= r_rd_en && (w_k == '0);
      r_wr_s1          <= r_rd_en && (w_k == K_LAST);
      r_waddr_s1       <= r_rd_en ? w_waddr_cur : '0;
      r_last_s1        <= r_rd_en && w_last;
      r_last_s2        <= r_last_s1;
      r_res_wr_en      <= r_wr_s1;
      r_res_wr_address <= r_wr_s1 ? r_waddr_s1 : '0;
      r_done           <= (r_state == ST_DRAIN) && r_last_s2;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign rd_en          = r_rd_en;
  assign rd_address_a   = r_rd_address_a;
  assign rd_address_b   = r_rd_address_b;
  assign mac_en         = r_mac_en;
  assign mac_first      = r_mac_first;
  assign res_wr_en      = r_res_wr_en;
  assign res_wr_address = r_res_wr_address;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: N=2 timing/control scenarios and an
// N=4 run against memory and MAC models.
module tb_matmul_sequencer;

  logic clk;
  logic rst_n;
  logic start2;
  logic start4;

  logic       d2_busy, d2_done, d2_rd_en, d2_mac_en, d2_mac_first, d2_res_wr_en;
  logic [1:0] d2_rd_address_a, d2_rd_address_b, d2_res_wr_address;
  logic       d4_busy, d4_done, d4_rd_en, d4_mac_en, d4_mac_first, d4_res_wr_en;
  logic [3:0] d4_rd_address_a, d4_rd_address_b, d4_res_wr_address;

  int errors;
  int checks;

  logic [17:0] exp_q[$];
  int          obs_a[$];
  int          obs_b[$];
  int          done_q[$];

  int a_mem [16];
  int b_mem [16];
  int res_mem [16];
  int rdata_a;
  int rdata_b;
  int acc;

  matmul_sequencer dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start2),
    .busy           (d2_busy),
    .done           (d2_done),
    .rd_en          (d2_rd_en),
    .rd_address_a   (d2_rd_address_a),
    .rd_address_b   (d2_rd_address_b),
    .mac_en         (d2_mac_en),
    .mac_first      (d2_mac_first),
    .res_wr_en      (d2_res_wr_en),
    .res_wr_address (d2_res_wr_address)
  );

  matmul_sequencer #(.MATRIX_DIM(4)) dut4 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start4),
    .busy           (d4_busy),
    .done           (d4_done),
    .rd_en          (d4_rd_en),
    .rd_address_a   (d4_rd_address_a),
    .rd_address_b   (d4_rd_address_b),
    .mac_en         (d4_mac_en),
    .mac_first      (d4_mac_first),
    .res_wr_en      (d4_res_wr_en),
    .res_wr_address (d4_res_wr_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories with 1-cycle read latency, a 1-cycle MAC and a result memory
  always @(posedge clk) begin
    if (d4_rd_en) begin
      rdata_a <= a_mem[d4_rd_address_a];
      rdata_b <= b_mem[d4_rd_address_b];
    end
    if (d4_mac_en) begin
      acc <= d4_mac_first ? rdata_a * rdata_b : acc + rdata_a * rdata_b;
    end
    if (d4_res_wr_en) begin
      res_mem[d4_res_wr_address] <= acc;
    end
  end

  // {busy, done, res_wr_en, res_addr[3:0], mac_en, mac_first, rd_en, addr_a[3:0], addr_b[3:0]}
  function automatic logic [17:0] obs2();
    return {d2_busy, d2_done, d2_res_wr_en, 2'b00, d2_res_wr_address, d2_mac_en, d2_mac_first,
            d2_rd_en, 2'b00, d2_rd_address_a, 2'b00, d2_rd_address_b};
  endfunction

  function automatic logic [17:0] obs4();
    return {d4_busy, d4_done, d4_res_wr_en, d4_res_wr_address, d4_mac_en, d4_mac_first,
            d4_rd_en, d4_rd_address_a, d4_rd_address_b};
  endfunction

  // Expected outputs 'off' cycles after the cycle in which start was accepted
  function automatic logic [17:0] exp_vec(input int n, input int off);
    int total, e;
    logic rd, me, mf, wr, dn, bz;
    logic [3:0] aa, ab, wa;
    total = n * n * n;
    rd = 1'b0; me = 1'b0; mf = 1'b0; wr = 1'b0;
    aa = 4'd0; ab = 4'd0; wa = 4'd0;
    if (off >= 1 && off <= total) begin
      rd = 1'b1;
      e  = off - 1;
      aa = 4'((e / (n * n)) * n + e % n);
      ab = 4'((e % n) * n + (e / n) % n);
    end
    if (off >= 2 && off <= total + 1) begin
      me = 1'b1;
      mf = ((off - 2) % n == 0);
    end
    if (off >= 3 && off <= total + 2 && ((off - 3) % n) == n - 1) begin
      wr = 1'b1;
      e  = off - 3;
      wa = 4'((e / (n * n)) * n + (e / n) % n);
    end
    dn = (off == total + 3);
    bz = (off >= 1 && off <= total + 3);
    return {bz, dn, wr, wa, me, mf, rd, aa, ab};
  endfunction

  // Drive a start/reset schedule cycle by cycle; compare every cycle against the scoreboard
  task automatic run_sched(input string name, input int dim, input int ncyc,
                           input logic [127:0] start_mask, input int rst_cycle);
    logic [17:0] o, e;
    logic st, active;
    int run_start, total;
    exp_q.delete(); obs_a.delete(); obs_b.delete(); done_q.delete();
    active = 1'b0; run_start = 0; total = dim * dim * dim;
    exp_q.push_back(18'd0);
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk); #1;
      rst_n = (t == rst_cycle) ? 1'b0 : 1'b1;
      st = start_mask[t];
      if (dim == 2) start2 = st; else start4 = st;
      if (!rst_n) begin
        active = 1'b0;
      end else if (st && (!active || (t - run_start) >= total + 4)) begin
        active = 1'b1;
        run_start = t;
      end
      exp_q.push_back(active ? exp_vec(dim, t + 1 - run_start) : 18'd0);
      @(negedge clk);
      o = (dim == 2) ? obs2() : obs4();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs got %h expected %h", name, t, o, e);
      end
      if (o[8]) begin
        obs_a.push_back(int'(o[7:4]));
        obs_b.push_back(int'(o[3:0]));
      end
      if (o[16]) done_q.push_back(t);
    end
    @(posedge clk); #1;
    start2 = 1'b0; start4 = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start2 = 1'b0; start4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs2() !== 18'd0) begin
        errors++;
        $display("FAIL reset_n2 cycle %0d: got %h expected 0", c, obs2());
      end
      checks++;
      if (obs4() !== 18'd0) begin
        errors++;
        $display("FAIL reset_n4 cycle %0d: got %h expected 0", c, obs4());
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int exp_a [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int exp_b [8] = '{0, 2, 1, 3, 0, 2, 1, 3};
    logic [127:0] m;
    m = '0; m[0] = 1'b1;
    run_sched("basic", 2, 14, m, -1);
    checks++;
    if (obs_a.size() != 8) begin
      errors++;
      $display("FAIL basic_rd_count: got %0d expected 8", obs_a.size());
    end
    for (int n = 0; n < 8; n++) begin
      if (n < obs_a.size()) begin
        checks++;
        if (obs_a[n] != exp_a[n] || obs_b[n] != exp_b[n]) begin
          errors++;
          $display("FAIL basic_addr[%0d]: got a=%0d b=%0d expected a=%0d b=%0d",
                   n, obs_a[n], obs_b[n], exp_a[n], exp_b[n]);
        end
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != 11) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses first=%0d expected one at 11",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] m;
    m = '0; m[0] = 1'b1; m[3] = 1'b1; m[11] = 1'b1; m[12] = 1'b1;
    run_sched("back_to_back", 2, 26, m, -1);
    checks++;
    if (done_q.size() != 2 || done_q[0] != 11 || done_q[1] != 23) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses first=%0d expected at 11 and 23",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
    checks++;
    if (obs_a.size() != 16) begin
      errors++;
      $display("FAIL b2b_rd_count: got %0d expected 16", obs_a.size());
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] m;
    m = '0; m[0] = 1'b1; m[8] = 1'b1;
    run_sched("mid_reset", 2, 22, m, 5);
    checks++;
    if (done_q.size() != 1 || done_q[0] != 19) begin
      errors++;
      $display("FAIL midrst_done: got %0d pulses first=%0d expected one at 19",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
  endtask

  task automatic test_n4_identity();
    logic [127:0] m;
    for (int w = 0; w < 16; w++) begin
      a_mem[w] = ((w / 4) == (w % 4)) ? 1 : 0;
      b_mem[w] = w + 1;
      res_mem[w] = -1;
    end
    m = '0; m[0] = 1'b1;
    run_sched("n4", 4, 70, m, -1);
    checks++;
    if (done_q.size() != 1 || done_q[0] != 67) begin
      errors++;
      $display("FAIL n4_done: got %0d pulses first=%0d expected one at 67",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (res_mem[w] != w + 1) begin
        errors++;
        $display("FAIL n4_result[%0d]: got %0d expected %0d", w, res_mem[w], w + 1);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    start2 = 1'b0;
    start4 = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_mid_reset();
    test_n4_identity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
